// File: rtl/lector_instrucciones.sv
// Instruction fetch unit: takes one word-address request from the program
// counter, issues a single memory read, waits (with timeout) for the data and
// delivers it as a one-cycle lectura_completada pulse.
// Optional one-entry delivery buffer enabled by the LECTOR_BUFFER_EN macro.
module lector_instrucciones #(
   parameter int TIMEOUT_CICLOS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        leer_siguiente_inst,
   input  logic [13:0] direccion_siguiente_inst,
   input  logic        reiniciar,
   input  logic [31:0] mem_dato,
   input  logic        mem_dato_valido,
   input  logic        mem_espera,
   output logic [13:0] mem_direccion,
   output logic        mem_leer,
   output logic        lectura_completada,
   output logic [31:0] instruccion_actual,
   output logic        error_lectura
);

   localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
   localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT_CICLOS - 1);
   localparam logic [31:0] PALABRA_ERROR = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      REPOSO,
      EMITIR,
      ESPERAR_DATO,
      ENTREGAR,
      DESCARTAR
   } estado_t;

   estado_t       estado, estado_sig;
   logic [CW-1:0] contador;
   logic [31:0]   dato_reg;
   logic          es_timeout;
   logic          vence;
   logic          acierto;
   logic [31:0]   dato_buffer;

   // control strobes decoded together with the next state
   logic iniciar_lectura;
   logic cargar_mem;
   logic cargar_buf;
   logic cargar_timeout;
   logic entregar;

   // last cycle of the wait window: no data for TIMEOUT_CICLOS cycles
   assign vence = (contador == LIMITE);

   // read strobe is a pure function of the state, so an async reset drops it at once
   assign mem_leer = (estado == EMITIR);

   // a delivery happens at the end of ENTREGAR unless it is being aborted
   assign entregar = (estado == ENTREGAR) && !reiniciar;

`ifdef LECTOR_BUFFER_EN
   logic        buf_valido;
   logic [13:0] buf_dir;
   logic [31:0] buf_dato;
   logic [13:0] dir_cap;

   assign acierto     = buf_valido && (buf_dir == direccion_siguiente_inst);
   assign dato_buffer = buf_dato;

   // one-entry buffer: filled on real deliveries, dropped on abort or timeout
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_valido <= 1'b0;
         buf_dir    <= '0;
         buf_dato   <= '0;
         dir_cap    <= '0;
      end else begin
         if (estado == REPOSO && leer_siguiente_inst && !reiniciar)
            dir_cap <= direccion_siguiente_inst;
         if (reiniciar || cargar_timeout) begin
            buf_valido <= 1'b0;
         end else if (entregar && !es_timeout) begin
            buf_valido <= 1'b1;
            buf_dir    <= dir_cap;
            buf_dato   <= dato_reg;
         end
      end
   end
`else
   assign acierto     = 1'b0;
   assign dato_buffer = '0;
`endif

   // state register
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state is updated with <= so every flop samples the pre-edge values.
      if (!reset) estado <= REPOSO;
      else        estado <= estado_sig;
   end

   // next-state and control strobe decode
   always_comb begin
      // NOTE: every output of this block gets a default first, otherwise a
      // path that does not assign it would infer a latch.
      estado_sig      = estado;
      iniciar_lectura = 1'b0;
      cargar_mem      = 1'b0;
      cargar_buf      = 1'b0;
      cargar_timeout  = 1'b0;
      unique case (estado)
         REPOSO: begin
            if (leer_siguiente_inst && !reiniciar) begin
               if (acierto) begin
                  estado_sig = ENTREGAR;
                  cargar_buf = 1'b1;
               end else begin
                  estado_sig      = EMITIR;
                  iniciar_lectura = 1'b1;
               end
            end
         end
         EMITIR: begin
            if (reiniciar) begin
               estado_sig = REPOSO;
            end else if (!mem_espera) begin
               // data already valid in the acceptance cycle is taken directly
               if (mem_dato_valido) begin
                  estado_sig = ENTREGAR;
                  cargar_mem = 1'b1;
               end else begin
                  estado_sig = ESPERAR_DATO;
               end
            end
         end
         ESPERAR_DATO: begin
            if (reiniciar) begin
               // a response landing in the abort cycle is already consumed
               estado_sig = (mem_dato_valido || vence) ? REPOSO : DESCARTAR;
            end else if (mem_dato_valido) begin
               estado_sig = ENTREGAR;
               cargar_mem = 1'b1;
            end else if (vence) begin
               estado_sig     = ENTREGAR;
               cargar_timeout = 1'b1;
            end
         end
         ENTREGAR: begin
            estado_sig = REPOSO;
         end
         DESCARTAR: begin
            if (mem_dato_valido || vence) estado_sig = REPOSO;
         end
         default: begin
            estado_sig = REPOSO;
         end
      endcase
   end

   // wait counter: runs only while a response is outstanding
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         contador <= '0;
      end else if ((estado == ESPERAR_DATO || estado == DESCARTAR) &&
                   (estado_sig == ESPERAR_DATO || estado_sig == DESCARTAR)) begin
         contador <= contador + 1'b1;
      end else begin
         contador <= '0;
      end
   end

   // address register and fetched-word holding register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_direccion <= '0;
         dato_reg      <= '0;
         es_timeout    <= 1'b0;
      end else begin
         if (iniciar_lectura) mem_direccion <= direccion_siguiente_inst;
         if (cargar_mem) begin
            dato_reg   <= mem_dato;
            es_timeout <= 1'b0;
         end else if (cargar_buf) begin
            dato_reg   <= dato_buffer;
            es_timeout <= 1'b0;
         end else if (cargar_timeout) begin
            dato_reg   <= PALABRA_ERROR;
            es_timeout <= 1'b1;
         end
      end
   end

   // delivery outputs and sticky error flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lectura_completada <= 1'b0;
         instruccion_actual <= '0;
         error_lectura      <= 1'b0;
      end else begin
         lectura_completada <= entregar;
         if (entregar) instruccion_actual <= dato_reg;
         if (cargar_timeout) error_lectura <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lector_instrucciones.sv
// Directed bench for lector_instrucciones: a table of single fetches with a
// cycle-level memory model, plus hand sequences for abort, async reset and
// the optional buffer (LECTOR_BUFFER_EN).
module tb_lector_instrucciones;

   logic        clk;
   logic        reset;
   logic        leer_siguiente_inst;
   logic [13:0] direccion_siguiente_inst;
   logic        reiniciar;
   logic [31:0] mem_dato;
   logic        mem_dato_valido;
   logic        mem_espera;
   logic [13:0] mem_direccion;
   logic        mem_leer;
   logic        lectura_completada;
   logic [31:0] instruccion_actual;
   logic        error_lectura;

   int total = 0;
   int bad   = 0;
   int pulsos = 0;

   typedef struct {
      logic [13:0] dir;
      logic [31:0] dato;
      int          espera;    // stall cycles before acceptance
      int          k;         // data valid k cycles after acceptance
      bit          con_dato;  // 0: memory never answers
      int          lat;       // edges from request sample to pulse
      logic [31:0] instr;
      bit          err;
      int          leeres;    // cycles with mem_leer=1
   } vec_t;

   vec_t tabla [8];

   lector_instrucciones #(.TIMEOUT_CICLOS(16)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .leer_siguiente_inst      (leer_siguiente_inst),
      .direccion_siguiente_inst (direccion_siguiente_inst),
      .reiniciar                (reiniciar),
      .mem_dato                 (mem_dato),
      .mem_dato_valido          (mem_dato_valido),
      .mem_espera               (mem_espera),
      .mem_direccion            (mem_direccion),
      .mem_leer                 (mem_leer),
      .lectura_completada       (lectura_completada),
      .instruccion_actual       (instruccion_actual),
      .error_lectura            (error_lectura)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
      total++;
      if (actual !== esperado) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nombre, actual, esperado);
      end
   endtask

   // advance one clock and sample 1 time unit after the edge
   task automatic ciclo();
      @(posedge clk);
      #1;
      if (lectura_completada === 1'b1) pulsos++;
   endtask

   // one complete fetch with the bench acting as memory
   task automatic fetch(input string nombre, input logic [13:0] dir, input logic [31:0] dato,
                        input int espera, input int k, input bit con_dato, input int lat_esp,
                        input logic [31:0] instr_esp, input bit err_esp, input int leeres_esp);
      int st = espera;
      int acc = -1;
      int lat = -1;
      int leeres = 0;
      bit dir_ok = 1'b1;
      leer_siguiente_inst      = 1'b1;
      direccion_siguiente_inst = dir;
      for (int n = 1; n <= 60 && lat < 0; n++) begin
         mem_espera = 1'b0;
         if (acc >= 0) begin
            acc++;
         end else if (mem_leer) begin
            if (st > 0) begin
               mem_espera = 1'b1;
               st--;
            end else begin
               acc = 0;
            end
         end
         if (mem_leer) begin
            leeres++;
            if (mem_direccion !== dir) dir_ok = 1'b0;
         end
         mem_dato_valido = con_dato && (acc == k);
         mem_dato        = mem_dato_valido ? dato : 32'h5A5A_5A5A;
         ciclo();
         leer_siguiente_inst = 1'b0;
         if (lectura_completada === 1'b1) lat = n;
      end
      if (lat < 0) $display("FAIL %s_wait: no pulse within 60 cycles", nombre);
      check({nombre, "_lat"}, lat, lat_esp);
      check({nombre, "_instr"}, instruccion_actual, instr_esp);
      check({nombre, "_err"}, {31'd0, error_lectura}, {31'd0, err_esp});
      check({nombre, "_leeres"}, leeres, leeres_esp);
      check({nombre, "_dir"}, {31'd0, dir_ok}, 32'd1);
      mem_dato_valido = 1'b0;
      mem_espera      = 1'b0;
      ciclo();
      check({nombre, "_ancho"}, {31'd0, lectura_completada}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tabla[0] = '{14'h0005, 32'h1234_5678, 0,  2, 1'b1,  5, 32'h1234_5678, 1'b0, 1};
      tabla[1] = '{14'h0123, 32'hDEAD_BEEF, 3,  2, 1'b1,  8, 32'hDEAD_BEEF, 1'b0, 4};
      tabla[2] = '{14'h3FFF, 32'h0000_0001, 0,  0, 1'b1,  3, 32'h0000_0001, 1'b0, 1};
      tabla[3] = '{14'h0000, 32'hCAFE_F00D, 1,  1, 1'b1,  5, 32'hCAFE_F00D, 1'b0, 2};
      tabla[4] = '{14'h0040, 32'h0000_0000, 0,  0, 1'b0, 19, 32'hFFFF_FFFF, 1'b1, 1};
      tabla[5] = '{14'h0041, 32'h0BAD_C0DE, 0,  1, 1'b1,  4, 32'h0BAD_C0DE, 1'b1, 1};
      tabla[6] = '{14'h2AAA, 32'h8765_4321, 2,  0, 1'b1,  5, 32'h8765_4321, 1'b1, 3};
      tabla[7] = '{14'h0042, 32'h0000_0000, 2,  0, 1'b0, 21, 32'hFFFF_FFFF, 1'b1, 3};

      reset = 1'b0;
      leer_siguiente_inst = 1'b0;
      direccion_siguiente_inst = '0;
      reiniciar = 1'b0;
      mem_dato = '0;
      mem_dato_valido = 1'b0;
      mem_espera = 1'b0;

      #12;
      check("rst_leer",  {31'd0, mem_leer}, 32'd0);
      check("rst_dir",   {18'd0, mem_direccion}, 32'd0);
      check("rst_pulso", {31'd0, lectura_completada}, 32'd0);
      check("rst_instr", instruccion_actual, 32'd0);
      check("rst_err",   {31'd0, error_lectura}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      ciclo();

      for (int i = 0; i < 8; i++) begin
         fetch($sformatf("v%0d", i), tabla[i].dir, tabla[i].dato, tabla[i].espera, tabla[i].k,
               tabla[i].con_dato, tabla[i].lat, tabla[i].instr, tabla[i].err, tabla[i].leeres);
      end

      // abort while waiting: late data must be swallowed
      pulsos = 0;
      leer_siguiente_inst = 1'b1;
      direccion_siguiente_inst = 14'h0100;
      ciclo();
      leer_siguiente_inst = 1'b0;
      check("a_emitir", {31'd0, mem_leer}, 32'd1);
      ciclo();
      reiniciar = 1'b1;
      ciclo();
      reiniciar = 1'b0;
      ciclo();
      mem_dato_valido = 1'b1;
      mem_dato = 32'hAAAA_AAAA;
      ciclo();
      mem_dato_valido = 1'b0;
      repeat (8) ciclo();
      check("a_pulsos", pulsos, 0);
      check("a_instr", instruccion_actual, 32'hFFFF_FFFF);
      check("a_leer", {31'd0, mem_leer}, 32'd0);
      fetch("a_sig", 14'h0101, 32'h1111_2222, 0, 1, 1'b1, 4, 32'h1111_2222, 1'b1, 1);

      // abort during delivery: no pulse, no update
      pulsos = 0;
      leer_siguiente_inst = 1'b1;
      direccion_siguiente_inst = 14'h0200;
      ciclo();
      leer_siguiente_inst = 1'b0;
      mem_dato_valido = 1'b1;
      mem_dato = 32'h3333_4444;
      ciclo();
      mem_dato_valido = 1'b0;
      reiniciar = 1'b1;
      ciclo();
      reiniciar = 1'b0;
      repeat (3) ciclo();
      check("b_pulsos", pulsos, 0);
      check("b_instr", instruccion_actual, 32'h1111_2222);

      // asynchronous reset in the middle of EMITIR
      leer_siguiente_inst = 1'b1;
      direccion_siguiente_inst = 14'h0300;
      ciclo();
      leer_siguiente_inst = 1'b0;
      mem_espera = 1'b1;
      check("c_emitir", {31'd0, mem_leer}, 32'd1);
      check("c_dir_emitir", {18'd0, mem_direccion}, 32'h0300);
      #3 reset = 1'b0;
      #1;
      check("c_leer", {31'd0, mem_leer}, 32'd0);
      check("c_dir", {18'd0, mem_direccion}, 32'd0);
      check("c_instr", instruccion_actual, 32'd0);
      check("c_err", {31'd0, error_lectura}, 32'd0);
      check("c_pulso", {31'd0, lectura_completada}, 32'd0);
      mem_espera = 1'b0;
      mem_dato_valido = 1'b1;
      mem_dato = 32'hBEEF_BEEF;
      @(posedge clk);
      #1 reset = 1'b1;
      pulsos = 0;
      repeat (3) ciclo();
      mem_dato_valido = 1'b0;
      ciclo();
      check("c_tarde_pulsos", pulsos, 0);
      check("c_tarde_instr", instruccion_actual, 32'd0);
      fetch("c_sig", 14'h0301, 32'h0F0F_0F0F, 0, 2, 1'b1, 5, 32'h0F0F_0F0F, 1'b0, 1);

`ifdef LECTOR_BUFFER_EN
      fetch("d_1", 14'h0010, 32'h5555_AAAA, 0, 1, 1'b1, 4, 32'h5555_AAAA, 1'b0, 1);
      fetch("d_hit", 14'h0010, 32'h9999_9999, 0, 0, 1'b1, 2, 32'h5555_AAAA, 1'b0, 0);
      reiniciar = 1'b1;
      ciclo();
      reiniciar = 1'b0;
      fetch("d_inv", 14'h0010, 32'h6666_7777, 0, 0, 1'b1, 3, 32'h6666_7777, 1'b0, 1);
`else
      fetch("d_1", 14'h0010, 32'h5555_AAAA, 0, 1, 1'b1, 4, 32'h5555_AAAA, 1'b0, 1);
      fetch("d_2", 14'h0010, 32'h6666_7777, 0, 1, 1'b1, 4, 32'h6666_7777, 1'b0, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lector_instrucciones.md
LECTOR_INSTRUCCIONES -- requirements
Module: lector_instrucciones

Interface
REQ-001 SHALL have parameter TIMEOUT_CICLOS, default 16: maximum cycles waited for memory data after the read is accepted.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately.
REQ-004 SHALL have port leer_siguiente_inst  input  1  fetch request from program_counter, sampled in REPOSO only.
REQ-005 SHALL have port direccion_siguiente_inst  input  14  word address, captured with the request.
REQ-006 SHALL have port reiniciar  input  1  abort the fetch in flight and invalidate the buffer.
REQ-007 SHALL have port mem_dato  input  32  memory read data.
REQ-008 SHALL have port mem_dato_valido  input  1  mem_dato valid this cycle.
REQ-009 SHALL have port mem_espera  input  1  memory stall; while it is 1, a read is not accepted.
REQ-010 SHALL have port mem_direccion  output  14  memory word address.
REQ-011 SHALL have port mem_leer  output  1  memory read strobe.
REQ-012 SHALL have port lectura_completada  output  1  one-cycle pulse: instruccion_actual is new.
REQ-013 SHALL have port instruccion_actual  output  32  last delivered instruction, held between pulses.
REQ-014 SHALL have port error_lectura  output  1  sticky timeout flag.

Function
REQ-015 SHALL implement the states REPOSO, EMITIR, ESPERAR_DATO, ENTREGAR and DESCARTAR.
REQ-016 REPOSO: with leer_siguiente_inst=1, SHALL capture the address and go to EMITIR; all other inputs are ignored.
REQ-017 EMITIR: SHALL drive mem_leer=1 and mem_direccion=the captured address; it SHALL remain in EMITIR while mem_espera=1, and SHALL go to ESPERAR_DATO on the first edge with mem_espera=0.
REQ-018 ESPERAR_DATO: on the first cycle with mem_dato_valido=1, SHALL register mem_dato and go to ENTREGAR; mem_dato_valido in the acceptance cycle also counts.
REQ-019 ENTREGAR: SHALL drive lectura_completada=1 for exactly one cycle, with instruccion_actual updated in the same cycle, then return to REPOSO.
REQ-020 Latency: with mem_espera=0 and data valid k cycles after acceptance, the pulse SHALL occur k+3 cycles after the request edge.
REQ-021 Timeout: a counter SHALL count cycles in ESPERAR_DATO; on reaching TIMEOUT_CICLOS without valid data, the block SHALL go to ENTREGAR with instruccion_actual=32'hFFFF_FFFF and set error_lectura=1.
REQ-022 error_lectura SHALL stay set until reset.
REQ-023 reiniciar in REPOSO, EMITIR or ENTREGAR SHALL go to REPOSO with no pulse; in ENTREGAR, the instruccion_actual update SHALL be suppressed.
REQ-024 reiniciar in ESPERAR_DATO SHALL go to DESCARTAR, which waits for mem_dato_valido or the timeout, discards it without setting error_lectura, then returns to REPOSO with no pulse.
REQ-025 reiniciar SHALL take priority over all simultaneous events.
REQ-026 mem_dato_valido seen in REPOSO, EMITIR or ENTREGAR SHALL be ignored.
REQ-027 Requests arriving outside REPOSO SHALL be ignored; the upstream block waits for lectura_completada.
REQ-028 mem_leer SHALL be 1 only in EMITIR; mem_direccion SHALL hold its last value otherwise.

Reset
REQ-029 reset=0 SHALL set state=REPOSO, mem_leer=0, mem_direccion=0, lectura_completada=0, instruccion_actual=0, error_lectura=0, timeout counter=0 and buffer invalid, regardless of the clock.
REQ-030 A reset mid-fetch SHALL abandon the fetch; late memory data SHALL be ignored per REQ-026.

Configuration
REQ-031 With LECTOR_BUFFER_EN defined, SHALL keep a one-entry buffer holding the last delivered address and data plus a valid bit.
REQ-032 With LECTOR_BUFFER_EN defined, a request hitting a valid entry SHALL go from REPOSO directly to ENTREGAR, giving the pulse 2 cycles after the request edge, with mem_leer=0.
REQ-033 With LECTOR_BUFFER_EN defined, the buffer SHALL be invalidated by reset, reiniciar and any timeout, and SHALL not be filled by timeout words.
REQ-034 Without LECTOR_BUFFER_EN, SHALL have no buffer logic, and every request SHALL go to memory.

Verification
REQ-035 Request address 0x0005, mem_espera=0, data 0x1234_5678 valid 2 cycles after acceptance -> one lectura_completada pulse 5 cycles after request, instruccion_actual=0x1234_5678.
REQ-036 mem_espera=1 for 3 cycles -> mem_leer held 4 cycles with mem_direccion stable; completion delayed by 3 cycles.
REQ-037 No mem_dato_valido -> after 16 wait cycles, pulse with 0xFFFF_FFFF and error_lectura=1, which stays set across later good reads.
REQ-038 reiniciar while waiting, then data 0xAAAA_AAAA -> no pulse, instruccion_actual unchanged; next request fetches normally.
REQ-039 With LECTOR_BUFFER_EN, two requests to 0x0010 -> the second completes in 2 cycles with mem_leer=0; a request after reiniciar issues mem_leer again.
REQ-040 reset=0 asynchronously during EMITIR -> mem_leer=0 and all outputs zero before the next edge.
